// File: rtl/ff_sched_pkg.sv
// Shared types for the two-channel round-robin accumulator scheduler.
// Holds the FSM state encoding, datapath widths and the saturating add.
package ff_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [3:0] data_t;
    typedef logic [4:0] sum_t;

    // The sum is formed one bit wider than the operands so a+b never wraps
    // before it is compared against the ceiling.
    function automatic data_t sat_add(input data_t a, input data_t b, input data_t ceiling);
        sum_t sum;
        sum = sum_t'(a) + sum_t'(b);
        return (sum > sum_t'(ceiling)) ? ceiling : data_t'(sum);
    endfunction

endpackage : ff_sched_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the preferred channel,
// the other channel wins only when the preferred one is idle. Purely combinational.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    // NOTE: every output of an always_comb gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    always_comb begin
        grant = 2'b00;
        if (valid[pointer]) begin
            grant[pointer] = 1'b1;
        end else if (valid[~pointer]) begin
            grant[~pointer] = 1'b1;
        end
    end

endmodule : rr_arb2

// File: rtl/ff_rr_sched.sv
// Two-channel request scheduler: grants one channel round-robin, adds its operands
// into a shared saturating accumulator and returns the result over a valid/ready port.
module ff_rr_sched
    import ff_sched_pkg::*;
#(
    parameter int MAX_COUNT = 10,
    parameter int START_VAL = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_a0,
    input  logic [3:0] req_b0,
    input  logic [3:0] req_a1,
    input  logic [3:0] req_b1,
    output logic [1:0] req_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_id,
    output logic       busy
);

    localparam data_t MAX_D   = data_t'(MAX_COUNT);
    localparam data_t START_D = data_t'(START_VAL);

    state_t     state_q;
    state_t     state_d;
    data_t      acc_q;
    data_t      op_a_q;
    data_t      op_b_q;
    logic       id_q;
    logic       ptr_q;
    logic [1:0] grant;
    logic       capture;
    logic       exec_en;
    logic       complete;

    rr_arb2 u_arb (
        .valid   (req_valid),
        .pointer (ptr_q),
        .grant   (grant)
    );

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        res_valid = 1'b0;
        capture   = 1'b0;
        exec_en   = 1'b0;
        complete  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    req_ready = grant;
                    capture   = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                exec_en = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                // Returning to IDLE rather than re-arbitrating here keeps the
                // pointer update and the next grant in separate cycles.
                if (res_ready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result fields read zero outside RESP so nothing stale leaks out.
    always_comb begin
        res_data = res_valid ? acc_q : '0;
        res_id   = res_valid & id_q;
        busy     = (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= START_D;
            op_a_q <= '0;
            op_b_q <= '0;
            id_q   <= 1'b0;
            ptr_q  <= 1'b0;
        end else begin
            if (capture) begin
                op_a_q <= grant[1] ? req_a1 : req_a0;
                op_b_q <= grant[1] ? req_b1 : req_b0;
                id_q   <= grant[1];
            end
            // A zero/zero operation is a read of the accumulator, not a clear.
            if (exec_en && !(op_a_q == '0 && op_b_q == '0)) begin
                acc_q <= sat_add(op_a_q, op_b_q, MAX_D);
            end
            if (complete) begin
                ptr_q <= ~id_q;
            end
        end
    end

endmodule : ff_rr_sched

// File: tb/tb_ff_rr_sched.sv
// Directed bench for ff_rr_sched: default instance plus a MAX_COUNT=15 instance
// for the saturation ceiling. Inputs change at posedge+1, outputs sampled at posedge+2.
module tb_ff_rr_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [3:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [1:0] req_ready;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic       res_id;
    logic       busy;

    logic [1:0] req_valid15 = 2'b00;
    logic [3:0] req_a1_15 = '0, req_b1_15 = '0;
    logic [1:0] req_ready15;
    logic       res_valid15;
    logic       res_ready15 = 1'b0;
    logic [3:0] res_data15;
    logic       res_id15;
    logic       busy15;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ff_rr_sched dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    ff_rr_sched #(.MAX_COUNT(15), .START_VAL(5)) dut15 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid15),
        .req_a0    (4'd0),
        .req_b0    (4'd0),
        .req_a1    (req_a1_15),
        .req_b1    (req_b1_15),
        .req_ready (req_ready15),
        .res_valid (res_valid15),
        .res_ready (res_ready15),
        .res_data  (res_data15),
        .res_id    (res_id15),
        .busy      (busy15)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 of an IDLE cycle with inputs driven and res_ready=1;
    // returns at posedge+1 of the following IDLE cycle.
    task automatic serve(input string tag, input logic [1:0] exp_grant,
                         input logic [3:0] exp_data, input logic exp_id);
        #1;
        check({tag, " grant"}, 8'(req_ready), 8'(exp_grant));
        check({tag, " idle busy"}, 8'(busy), 8'h00);
        tick();
        #1;
        check({tag, " exec ready"}, 8'(req_ready), 8'h00);
        check({tag, " exec valid"}, 8'(res_valid), 8'h00);
        check({tag, " exec busy"}, 8'(busy), 8'h01);
        tick();
        #1;
        check({tag, " resp valid"}, 8'(res_valid), 8'h01);
        check({tag, " resp data"}, 8'(res_data), 8'(exp_data));
        check({tag, " resp id"}, 8'(res_id), 8'(exp_id));
        tick();
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b1;
        #1;
        check("rst busy", 8'(busy), 8'h00);
        check("rst req_ready", 8'(req_ready), 8'h00);
        check("rst res_valid", 8'(res_valid), 8'h00);
        check("rst res_data", 8'(res_data), 8'h00);
        check("rst res_id", 8'(res_id), 8'h00);
        tick();
        tick();
        reset = 1'b0;

        // Basic request on ch0: 2+3 = 5, result two cycles after acceptance
        req_valid = 2'b01; req_a0 = 4'd2; req_b0 = 4'd3; res_ready = 1'b1;
        serve("basic", 2'b01, 4'd5, 1'b0);
        req_valid = 2'b00;
        #1;
        check("basic back idle", 8'(busy), 8'h00);
        check("basic no result", 8'(res_valid), 8'h00);

        // Fresh reset so the pointer starts at ch0, then both channels contend
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 2'b11;
        req_a0 = 4'd1; req_b0 = 4'd1; req_a1 = 4'd4; req_b1 = 4'd4;
        serve("rr0", 2'b01, 4'd2, 1'b0);
        serve("rr1", 2'b10, 4'd8, 1'b1);
        serve("rr2", 2'b01, 4'd2, 1'b0);

        // Saturation: pointer now prefers ch1; 9+9=18 clamps to 10
        req_valid = 2'b10; req_a1 = 4'd9; req_b1 = 4'd9;
        serve("sat10", 2'b10, 4'd10, 1'b1);

        // Backpressure: ch0 wins (pointer at ch0), ch1 waits for the handshake
        req_valid = 2'b11;
        req_a0 = 4'd3; req_b0 = 4'd4; req_a1 = 4'd2; req_b1 = 4'd1;
        res_ready = 1'b0;
        #1;
        check("bp grant", 8'(req_ready), 8'h01);
        tick();
        req_a0 = 4'd15; req_b0 = 4'd15; res_ready = 1'b1;
        #1;
        check("bp exec valid", 8'(res_valid), 8'h00);
        tick();
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bp hold%0d valid", i), 8'(res_valid), 8'h01);
            check($sformatf("bp hold%0d data", i), 8'(res_data), 8'h07);
            check($sformatf("bp hold%0d id", i), 8'(res_id), 8'h00);
            check($sformatf("bp hold%0d ready", i), 8'(req_ready), 8'h00);
            tick();
        end
        res_ready = 1'b1;
        #1;
        check("bp final data", 8'(res_data), 8'h07);
        tick();
        serve("bp ch1", 2'b10, 4'd3, 1'b1);
        req_valid = 2'b00;

        // Reset during EXEC abandons the operation and reloads START_VAL
        req_valid = 2'b01; req_a0 = 4'd6; req_b0 = 4'd2;
        #1;
        check("abort grant", 8'(req_ready), 8'h01);
        tick();
        req_valid = 2'b00;
        reset = 1'b1;
        #1;
        check("abort busy", 8'(busy), 8'h00);
        check("abort res_valid", 8'(res_valid), 8'h00);
        tick();
        #1;
        check("abort still quiet", 8'(res_valid), 8'h00);
        reset = 1'b0;
        tick();
        #1;
        check("abort idle", 8'(busy), 8'h00);
        check("abort no result", 8'(res_valid), 8'h00);
        req_valid = 2'b01; req_a0 = 4'd0; req_b0 = 4'd0;
        serve("hold start", 2'b01, 4'd5, 1'b0);
        req_valid = 2'b00;

        // MAX_COUNT=15 instance: 9+9 clamps to 15, never wraps to 2
        req_valid15 = 2'b10; req_a1_15 = 4'd9; req_b1_15 = 4'd9; res_ready15 = 1'b1;
        #1;
        check("sat15 grant", 8'(req_ready15), 8'h02);
        tick();
        req_valid15 = 2'b00;
        tick();
        #1;
        check("sat15 valid", 8'(res_valid15), 8'h01);
        check("sat15 data", 8'(res_data15), 8'h0f);
        check("sat15 id", 8'(res_id15), 8'h01);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_ff_rr_sched

// File: doc/ff_rr_sched.md
FF_RR_SCHED -- requirements
Module: ff_rr_sched

Interface
REQ-001 Parameter MAX_COUNT, default 10, SHALL be the saturation ceiling of the shared 4-bit accumulator (legal range 1..15).
REQ-002 Parameter START_VAL, default 5, SHALL be the accumulator value loaded on reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Ports req_valid, input, 2 bits: per-channel request valid (bit0 = ch0, bit1 = ch1).
REQ-006 Ports req_a0, req_b0, req_a1, req_b1, input, 4 bits each: operand pair per channel.
REQ-007 Port req_ready, output, 2 bits: per-channel accept strobe.
REQ-008 Port res_valid, output, 1 bit: result available.
REQ-009 Port res_ready, input, 1 bit: consumer accepts result.
REQ-010 Port res_data, output, 4 bits: accumulator value after the served operation.
REQ-011 Port res_id, output, 1 bit: channel that issued the served operation.
REQ-012 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-014 In IDLE with any req_valid bit set, the block SHALL grant exactly one channel, assert its req_ready bit combinationally in that cycle, capture its operands, and move to EXEC.
REQ-015 Arbitration SHALL be round-robin: a priority pointer, reset to ch0, names the preferred channel, and the non-preferred channel is granted only when the preferred one is not valid.
REQ-016 The priority pointer SHALL move to the channel other than the winner on each completed result handshake, and only then.
REQ-017 req_ready SHALL be 0 in EXEC and RESP, and SHALL never have both bits set.
REQ-018 In EXEC, the accumulator SHALL update once: it holds if a==0 and b==0; otherwise it loads min(a+b, MAX_COUNT) using a 5-bit sum, so there is no 4-bit wrap. The FSM then moves to RESP.
REQ-019 In RESP, res_valid SHALL be 1, res_data SHALL equal the accumulator, and res_id SHALL equal the granted channel; all three SHALL stay stable until res_ready is 1.
REQ-020 A RESP cycle with res_ready=1 SHALL complete the handshake and return the FSM to IDLE; no new grant occurs in that same cycle.
REQ-021 Latency: a request accepted in cycle N SHALL present res_valid in cycle N+2, giving a minimum service interval of 3 cycles per request.
REQ-022 res_ready asserted outside RESP SHALL be ignored.
REQ-023 A req_valid bit deasserted before its grant SHALL be dropped silently, with no state change.
REQ-024 Operands SHALL be taken only from the capture registers after acceptance; later changes on the req_* inputs SHALL not affect the result.

Reset
REQ-025 While reset=1 the block SHALL immediately hold: FSM=IDLE, accumulator=START_VAL, pointer=ch0, res_valid=0, res_data=0, res_id=0, req_ready=0, busy=0.
REQ-026 Reset asserted in EXEC or RESP SHALL abandon the in-flight operation with no result emitted, and the accumulator SHALL still reload START_VAL.
REQ-027 On the first clock after reset deasserts, the block SHALL arbitrate normally from IDLE.

Structure
REQ-028 A package ff_sched_pkg SHALL hold the FSM state enum (IDLE/EXEC/RESP), the 4-bit data typedef and the 5-bit sum typedef.
REQ-029 Round-robin grant logic SHALL live in a sub-module rr_arb2, taking (valid[1:0], pointer) and returning a one-hot grant, combinational only.
REQ-030 The accumulator, operand capture registers, pointer and FSM SHALL reside in ff_rr_sched.

Verification
REQ-031 Reset, then ch0 valid with a=2, b=3 and res_ready=1 -> req_ready=01 in cycle 0, res_valid in cycle 2 with res_data=5 and res_id=0.
REQ-032 Both channels valid continuously (ch0 a=1 b=1, ch1 a=4 b=4) -> grants alternate ch0, ch1, ch0; res_data sequence is 2, 8, 2.
REQ-033 ch1 with a=9, b=9 -> res_data=10 (saturated); repeat with MAX_COUNT=15 -> res_data=15, never 2.
REQ-034 ch0 with a=0, b=0 right after reset -> res_data=5 (hold of START_VAL).
REQ-035 res_ready held 0 for 4 cycles in RESP, with ch1 valid -> res_valid, res_data and res_id stay stable, req_ready=00, and ch1 is granted only after the handshake.
REQ-036 reset pulsed during EXEC -> no res_valid, busy=0 and accumulator=5 immediately; the next request a=0, b=0 returns 5.
